// File: rtl/voice_pkg.sv
// Shared definitions for the voice FIFO scheduler: read-sequencer state encoding,
// default sizing constants and a counter-width helper.
package voice_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int WAVE_SIZE_DEF  = 16;
  localparam int TIMEOUT_DEF    = 1023;
  localparam int MAX_RETRY_DEF  = 3;

  typedef enum logic [7:0] {
    ST_IDLE  = 8'h01,
    ST_REQ   = 8'h02,
    ST_WAIT  = 8'h04,
    ST_CHECK = 8'h08,
    ST_RETRY = 8'h10
  } rd_state_t;

  // Bits needed to hold values 0..max_val.
  function automatic int cnt_width(input int max_val);
    if (max_val < 1) return 1;
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/voice_rr_arb2.sv
// Two-way round-robin arbiter; history moves only when a grant is actually accepted,
// so a stall on full leaves the rotation where it was.
module voice_rr_arb2
  import voice_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_valid,
  input  logic       i_full,
  output logic [1:0] o_grant,
  output logic [1:0] o_ready
);

  logic last_q;  // 1 = channel 1 was granted most recently

  always_comb begin
    o_grant    = 2'b00;
    o_grant[0] = i_valid[0] & (~i_valid[1] | last_q);
    o_grant[1] = i_valid[1] & ~o_grant[0];
    o_ready    = o_grant & {2{~i_full}};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_q <= 1'b1;
    end else if (o_ready[0]) begin
      last_q <= 1'b0;
    end else if (o_ready[1]) begin
      last_q <= 1'b1;
    end
  end

endmodule

// File: rtl/voice_fifo_sched.sv
// Voice SDRAM FIFO front end: round-robin write arbitration for two capture channels
// and a retrying wave-read sequencer feeding the playback stream.
//
// state | meaning
// IDLE  | waiting for a playback request
// REQ   | read request asserted, no word seen yet
// WAIT  | words streaming, waiting for done
// CHECK | one cycle: report ok/err on the collected word count
// RETRY | one cycle: restart the attempt or report failure
module voice_fifo_sched
  import voice_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int WAVE_SIZE  = WAVE_SIZE_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF,
  parameter int MAX_RETRY  = MAX_RETRY_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_ch0_valid,
  input  logic [DATA_WIDTH-1:0] i_ch0_data,
  output logic                  o_ch0_ready,
  input  logic                  i_ch1_valid,
  input  logic [DATA_WIDTH-1:0] i_ch1_data,
  output logic                  o_ch1_ready,
  output logic                  o_fifo_wr,
  output logic [DATA_WIDTH-1:0] o_fifo_wr_data,
  input  logic                  i_fifo_full,
  output logic                  o_fifo_rd,
  input  logic [DATA_WIDTH-1:0] i_fifo_rd_data,
  input  logic                  i_fifo_rd_ef,
  input  logic                  i_fifo_rd_done,
  input  logic                  i_fifo_rd_fail,
  input  logic                  i_play_req,
  output logic                  o_play_valid,
  output logic [DATA_WIDTH-1:0] o_play_data,
  output logic                  o_busy,
  output logic                  o_wave_ok,
  output logic                  o_wave_err,
  output logic                  o_wave_fail
);

  localparam int TW = cnt_width(TIMEOUT);
  localparam int WW = cnt_width(WAVE_SIZE + 1);
  localparam int RW = cnt_width(MAX_RETRY);

  logic [1:0] grant;
  logic [1:0] ready;

  voice_rr_arb2 u_arb (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid ({i_ch1_valid, i_ch0_valid}),
    .i_full  (i_fifo_full),
    .o_grant (grant),
    .o_ready (ready)
  );

  always_comb begin
    o_ch0_ready    = ready[0];
    o_ch1_ready    = ready[1];
    o_fifo_wr      = |ready;
    o_fifo_wr_data = '0;
    if (grant[1])      o_fifo_wr_data = i_ch1_data;
    else if (grant[0]) o_fifo_wr_data = i_ch0_data;
  end

  rd_state_t             state_q, state_d;
  logic [TW-1:0]         tmo_q;
  logic [WW-1:0]         wcnt_q;
  logic [RW-1:0]         retry_q;
  logic                  play_valid_q;
  logic [DATA_WIDTH-1:0] play_data_q;
  logic                  tmo_hit;
  logic                  retry_left;

  assign tmo_hit    = (tmo_q == TW'(TIMEOUT));
  assign retry_left = (retry_q < RW'(MAX_RETRY));

  always_comb begin
    state_d     = state_q;
    o_fifo_rd   = 1'b0;
    o_busy      = (state_q != ST_IDLE);
    o_wave_ok   = 1'b0;
    o_wave_err  = 1'b0;
    o_wave_fail = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_play_req) state_d = ST_REQ;
      end
      ST_REQ: begin
        o_fifo_rd = 1'b1;
        if (i_fifo_rd_fail || tmo_hit) state_d = ST_RETRY;
        else if (i_fifo_rd_done)       state_d = ST_CHECK;
        else if (i_fifo_rd_ef)         state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_fifo_rd_fail || tmo_hit) state_d = ST_RETRY;
        else if (i_fifo_rd_done)       state_d = ST_CHECK;
      end
      ST_CHECK: begin
        o_wave_ok  = (wcnt_q == WW'(WAVE_SIZE));
        o_wave_err = (wcnt_q != WW'(WAVE_SIZE));
        state_d    = ST_IDLE;
      end
      ST_RETRY: begin
        o_wave_fail = ~retry_left;
        state_d     = retry_left ? ST_REQ : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      tmo_q        <= '0;
      wcnt_q       <= '0;
      retry_q      <= '0;
      play_valid_q <= 1'b0;
      play_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      play_valid_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (i_play_req) begin
            retry_q <= '0;
            tmo_q   <= '0;
            wcnt_q  <= '0;
          end
        end
        ST_REQ, ST_WAIT: begin
          tmo_q <= tmo_q + 1'b1;
          // Words past WAVE_SIZE are counted (for the err verdict) but not streamed.
          if (i_fifo_rd_ef) begin
            if (wcnt_q < WW'(WAVE_SIZE)) begin
              play_valid_q <= 1'b1;
              play_data_q  <= i_fifo_rd_data;
            end
            if (wcnt_q != WW'(WAVE_SIZE + 1)) wcnt_q <= wcnt_q + 1'b1;
          end
        end
        ST_RETRY: begin
          if (retry_left) begin
            retry_q <= retry_q + 1'b1;
            tmo_q   <= '0;
            wcnt_q  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_play_valid = play_valid_q;
  assign o_play_data  = play_data_q;

endmodule

// File: doc/voice_fifo_sched.md
Name: voice_fifo_sched

Overview:
Front-end scheduler for the voice SDRAM FIFO. It does two jobs:
- Arbitrates two sample-capture writer channels onto the FIFO's single write port, round-robin.
- Sequences wave-sized read requests for the playback path: it issues the read request, collects the returned words into a playback stream, checks the word count, and retries on fail or timeout.

It sits between the capture/playback logic and the SDRAM FIFO, and is the only agent that drives the FIFO's write and read controls.

Parameters:
- DATA_WIDTH, 16, sample width.
- WAVE_SIZE, 16, words per wave read.
- TIMEOUT, 1023, max cycles in REQ+WAIT before the attempt is abandoned.
- MAX_RETRY, 3, retries after the first attempt before reporting failure.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous, active-high reset.
- i_ch0_valid  in  1  writer 0 has a sample.
- i_ch0_data  in  DATA_WIDTH  writer 0 sample.
- o_ch0_ready  out  1  writer 0 sample accepted this cycle.
- i_ch1_valid / i_ch1_data / o_ch1_ready  same as ch0, for writer 1.
- o_fifo_wr  out  1  FIFO write strobe.
- o_fifo_wr_data  out  DATA_WIDTH  FIFO write data.
- i_fifo_full  in  1  FIFO full.
- o_fifo_rd  out  1  FIFO wave read request (level).
- i_fifo_rd_data  in  DATA_WIDTH  FIFO read data.
- i_fifo_rd_ef  in  1  read data valid.
- i_fifo_rd_done  in  1  wave read complete pulse.
- i_fifo_rd_fail  in  1  read failed pulse.
- i_play_req  in  1  playback requests one wave (pulse).
- o_play_valid  out  1  playback word valid.
- o_play_data  out  DATA_WIDTH  playback word.
- o_busy  out  1  read sequence in progress.
- o_wave_ok  out  1  pulse: wave delivered with exactly WAVE_SIZE words.
- o_wave_err  out  1  pulse: wave completed short or long.
- o_wave_fail  out  1  pulse: retries exhausted.

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous and active-high on i_rst.
- Reset values: every output is 0, except o_fifo_wr_data and o_play_data, which are 0 as well. FSM is in IDLE, last-grant = ch1 (so ch0 wins first), all counters are 0.
- Reset mid-read: FSM goes to IDLE on that edge and o_fifo_rd drops the following cycle. Words arriving afterwards are ignored.
- Write arbitration is combinational, with zero-latency accept:
  - grant0 = ch0_valid & (!ch1_valid | last==ch1).
  - grant1 = ch1_valid & !grant0.
  - o_chN_ready = grantN & !i_fifo_full.
  - o_fifo_wr = o_ch0_ready | o_ch1_ready.
  - o_fifo_wr_data is the data of the granted channel.
- Grant history: last-grant updates only on an accepted write. While i_fifo_full is high, no write and no grant-history change.
- Writes are never blocked by read activity.
- Read FSM:
  - IDLE: on i_play_req go to REQ; retry count := 0; timeout := 0; word count := 0. i_play_req while o_busy is ignored; there is no queueing.
  - REQ: o_fifo_rd = 1.
    - First i_fifo_rd_ef -> WAIT; that word is also captured.
    - i_fifo_rd_done -> CHECK.
  - WAIT: o_fifo_rd = 0.
    - Each i_fifo_rd_ef cycle: if word count < WAVE_SIZE, o_play_valid = 1 and o_play_data = i_fifo_rd_data on the next cycle (1-cycle registered latency). The word count increments, saturating at WAVE_SIZE+1. Words beyond WAVE_SIZE are dropped.
    - i_fifo_rd_done -> CHECK.
  - CHECK (1 cycle):
    - Word count == WAVE_SIZE: o_wave_ok pulse.
    - Otherwise: o_wave_err pulse.
    - Then -> IDLE.
  - In REQ or WAIT, i_fifo_rd_fail or timeout == TIMEOUT -> RETRY. Fail takes precedence over a same-cycle rd_done.
  - RETRY (1 cycle):
    - If retry count < MAX_RETRY: retry count++, timeout := 0, word count := 0 -> REQ.
    - Else: o_wave_fail pulse -> IDLE.
    - Words already streamed are not recalled.
- Timeout counter increments every cycle in REQ/WAIT and clears on entering REQ.
- o_busy = (state != IDLE).
- Simultaneous i_fifo_rd_ef and i_fifo_rd_done: the word is counted before CHECK evaluates.

Decomposition:
- Package voice_pkg holds the FSM state encoding (one-hot 8-bit, in codebase style), plus the TIMEOUT and retry constants and a clog2-based count-width function.
- One sub-module is natural: voice_rr_arb2, a 2-way round-robin arbiter with grant history.

Test Plan:
- Write arbitration: both writers valid continuously, full = 0 -> writes alternate ch0, ch1, ch0…; 8 cycles give 4 per channel, and ch0 is granted first after reset.
- Write backpressure: full = 1 for 5 cycles with both valid -> no o_fifo_wr, no readies. After full drops, the grant resumes from the pre-stall order.
- Normal wave read: i_play_req, ef for 16 words, then done -> 16 o_play_valid beats with matching data, each 1 cycle late, then o_wave_ok; o_busy high from req+1 to CHECK.
- Long and short waves: 18 ef words then done -> 16 output words and o_wave_err. 10 words then done -> 10 output words and o_wave_err.
- Fail and retry: i_fifo_rd_fail in WAIT on 4 consecutive attempts -> o_fifo_rd reasserted 3 times, then o_wave_fail. With TIMEOUT = 20 and no response -> RETRY after 20 cycles.
- Reset during WAIT: after 5 words, i_rst = 1 -> outputs 0 next cycle and later ef words are ignored; a new i_play_req starts a fresh wave.
